maxpool_ctrl: RTL and testbench
===============================

# maxpool_ctrl

Sequencer for the FP16 max-pooling datapath: accepts a channel-interleaved stream of window elements and issues compares to an external pipelined FP16 "greater-than" comparator. Keeps one running maximum per channel and emits one result per channel when the window completes. Interleaving channels hides comparator latency. A per-channel pending bit stalls input on read-after-write hazards when the channel count is small. Sits between the pooling input buffer and the output write-back stage.

## Interface
- DW, 16, data width (FP16)
- MAX_CH, 16, maximum interleaved channels (running-max registers)
- CH_W, $clog2(MAX_CH), channel index width
- WIN_W, 8, window element count width
- TAG_DEPTH, 4, in-flight compare tracking depth; must be ≥ comparator latency + 1
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cfg_start  in  1  start pulse; cfg_ch/cfg_win sampled this cycle
- cfg_ch  in  CH_W+1  channels 0..MAX_CH (0 = empty job)
- cfg_win  in  WIN_W  elements per window per channel (0 = empty job)
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at job end
- in_valid / in_ready  in / out  1 / 1  element handshake
- in_data  in  DW  element; channel order implicit (channel fastest, then window position)
- cmp_a, cmp_b  out  DW  operands: candidate, current max
- cmp_nd  out  1  new-data strobe to comparator
- cmp_rdy  in  1  result strobe; results return in issue order
- cmp_gt  in  1  result: a > b (false on unordered)
- out_valid / out_ready  out / in  1 / 1  result handshake
- out_data  out  DW  window maximum
- out_ch  out  CH_W  channel of out_data

## Operation
- States: IDLE, RUN, DRAIN, FLUSH.
- IDLE:
  - cfg_start latches config, clears counters ch=0, pos=0, and goes to RUN.
  - If cfg_ch==0 or cfg_win==0: pulse done the next cycle and stay in IDLE.
- cfg_start outside IDLE is ignored.
- RUN:
  - in_ready = !pending[ch] && tag FIFO not full.
  - On accept with pos==0: max[ch] <= in_data directly; no compare issued.
  - On accept with pos>0: set pending[ch]; push {ch, in_data} to tag FIFO; register cmp_a=in_data, cmp_b=max[ch], cmp_nd=1 for one cycle.
  - ch increments and wraps at cfg_ch-1; pos increments on wrap.
  - Accepting the last element (pos==cfg_win-1, ch==cfg_ch-1) moves to DRAIN.
- Any state, on cmp_rdy:
  - Pop the tag FIFO and clear pending[tag.ch].
  - If cmp_gt, max[tag.ch] <= tag.data; otherwise max is unchanged, so NaN candidates are dropped.
- DRAIN: wait for an empty FIFO with no pending bits, then go to FLUSH with idx=0.
- FLUSH:
  - out_valid=1, out_data=max[idx], out_ch=idx.
  - Advance idx on out_ready.
  - After idx==cfg_ch-1 transfers: pulse done and go to IDLE.
- Simultaneous pos==0 write and cmp_rdy write-back always target different channels, because pending blocks the accept. Both writes take effect.
- cmp_rdy with an empty FIFO is a protocol error; it is ignored and no state changes.

## Timing
- Reset values: busy=0, done=0, in_ready=0, cmp_nd=0, cmp_a=cmp_b=0, out_valid=0, out_data=0, out_ch=0, state=IDLE. All max registers, pending bits and the FIFO are cleared.
- Reset mid-job aborts immediately; no done pulse and no outputs.
- in_ready is combinational from registered state.
- cmp_nd is asserted exactly one cycle after the accepting edge.
- Throughput: 1 element/cycle when cfg_ch ≥ comparator latency + 1.
  - Otherwise the accept rate is limited per channel: the next element of a channel is accepted the cycle after its cmp_rdy.
- FLUSH output: 1 result/cycle with out_ready held high.
  - out_data and out_ch are held stable while out_valid && !out_ready.
- done is asserted the cycle after the final output handshake.
- busy falls in that same cycle.

## Configuration
- MAXPOOL_RELU_EN
  - Defined: out_data is forced to 16'h0000 when max[idx] has sign bit 1, i.e. fused ReLU.
  - Undefined: out_data = max[idx] unmodified.
- No other behaviour differs between the two builds.

## Structure
- Shared package holds:
  - the FP16 width constant;
  - the state enum;
  - a tag struct {ch, data};
  - the FP16 zero constant used by ReLU.
- One sub-module: pool_tag_fifo, a synchronous FIFO of depth TAG_DEPTH with push, pop, full and empty.
- Max registers and pending bits are flops inside maxpool_ctrl.

## Test plan
- Single channel, 4-element window:
  - Stimulus: cfg_ch=1, cfg_win=4, data 3C00, 4000, BC00, 3800; comparator latency 2.
  - Response: out_data=4000, out_ch=0. in_ready drops while each compare is pending. One done pulse.
- Interleaved channels:
  - Stimulus: cfg_ch=3, cfg_win=2, stream 3C00, 4200, C000, 4000, 3800, BC00.
  - Response: in_ready never drops. Outputs (0, 4000), (1, 4200), (2, BC00).
- ReLU:
  - Stimulus: cfg_ch=1, cfg_win=2, data B800, BC00.
  - Response: out_data=0000 with MAXPOOL_RELU_EN defined; B800 without.
- Backpressure: cfg_ch=2, cfg_win=1, out_ready low for 3 cycles → out_data/out_ch stable; both results delivered in order, and equal to the inputs.
- Abort and empty job:
  - Stimulus A: rst asserted mid-RUN, then a fresh cfg_ch=1, cfg_win=2 job.
  - Response A: all outputs at reset values, no stale max; the fresh job is correct.
  - Stimulus B: a cfg_win=0 job.
  - Response B: done with no out_valid.
- NaN candidate: cfg_ch=1, cfg_win=2, data 3C00, 7E00 → cmp_gt=0, out_data=3C00.

Source files
------------

// File: rtl/maxpool_ctrl_pkg.sv
// maxpool_ctrl_pkg: shared FP16 constants, sequencer states and compare tag type.
package maxpool_ctrl_pkg;
    localparam int FP16_W = 16;
    localparam int TAG_CH_W = 4;
    localparam logic [FP16_W-1:0] FP16_ZERO = '0;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FLUSH} state_t;
    typedef struct packed {
        logic [TAG_CH_W-1:0] ch;
        logic [FP16_W-1:0]   data;
    } tag_t;
endpackage

// File: rtl/maxpool_ctrl_tag_fifo.sv
// pool_tag_fifo: synchronous FIFO tracking in-flight compares in issue order.
module pool_tag_fifo import maxpool_ctrl_pkg::*; #(
    parameter int W = $bits(tag_t),
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic do_push, do_pop;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign full = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign rdata = mem[rp];
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wp] <= wdata;
                wp <= (wp == AW'(DEPTH - 1)) ? '0 : wp + 1'b1;
            end
            if (do_pop) rp <= (rp == AW'(DEPTH - 1)) ? '0 : rp + 1'b1;
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
endmodule

// File: rtl/maxpool_ctrl.sv
// maxpool_ctrl: channel-interleaved FP16 max-pool sequencer driving an external comparator.
// Build option MAXPOOL_RELU_EN fuses a ReLU onto the flushed results.
module maxpool_ctrl import maxpool_ctrl_pkg::*; #(
    parameter int DW = FP16_W,
    parameter int MAX_CH = 16,
    parameter int CH_W = $clog2(MAX_CH),
    parameter int WIN_W = 8,
    parameter int TAG_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_start,
    input  logic [CH_W:0]   cfg_ch,
    input  logic [WIN_W-1:0] cfg_win,
    output logic            busy,
    output logic            done,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    output logic [DW-1:0]   cmp_a,
    output logic [DW-1:0]   cmp_b,
    output logic            cmp_nd,
    input  logic            cmp_rdy,
    input  logic            cmp_gt,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic [CH_W-1:0] out_ch
);
    state_t state, nxt;
    logic [CH_W:0] nch;
    logic [WIN_W-1:0] nwin, pos;
    logic [CH_W-1:0] ch, idx;
    logic [DW-1:0] max_r [MAX_CH];
    logic [MAX_CH-1:0] pending;
    logic accept, issue, pop_ok, start_ok, start_empty, last_ch, last_pos, last_idx;
    logic fifo_full, fifo_empty;
    logic [$bits(tag_t)-1:0] fifo_rdata;
    tag_t tag_in, tag_out;
    assign start_ok = state == IDLE && cfg_start && cfg_ch != '0 && cfg_win != '0;
    assign start_empty = state == IDLE && cfg_start && (cfg_ch == '0 || cfg_win == '0);
    assign last_ch = {1'b0, ch} == nch - 1'b1;
    assign last_pos = pos == nwin - 1'b1;
    assign last_idx = {1'b0, idx} == nch - 1'b1;
    assign accept = in_valid && in_ready;
    assign issue = accept && pos != '0;
    assign pop_ok = cmp_rdy && !fifo_empty;
    assign tag_in = '{ch: TAG_CH_W'(ch), data: in_data};
    assign tag_out = tag_t'(fifo_rdata);
    pool_tag_fifo #(.W($bits(tag_t)), .DEPTH(TAG_DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(issue), .pop(cmp_rdy), .wdata(tag_in),
        .rdata(fifo_rdata), .full(fifo_full), .empty(fifo_empty)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= nxt;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start_ok ? RUN : IDLE;
            RUN:     nxt = (accept && last_ch && last_pos) ? DRAIN : RUN;
            DRAIN:   nxt = (fifo_empty && pending == '0) ? FLUSH : DRAIN;
            FLUSH:   nxt = (out_ready && last_idx) ? IDLE : FLUSH;
            default: nxt = IDLE;
        endcase
    end
    always_comb begin
        busy = state != IDLE;
        in_ready = state == RUN && !pending[ch] && !fifo_full;
        out_valid = state == FLUSH;
        out_ch = out_valid ? idx : '0;
`ifdef MAXPOOL_RELU_EN
        out_data = (out_valid && !max_r[idx][DW-1]) ? max_r[idx] : FP16_ZERO;
`else
        out_data = out_valid ? max_r[idx] : FP16_ZERO;
`endif
    end
    // A channel's max is only written by its first element or its own write-back;
    // pending guarantees those two never collide on one channel.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            done <= 1'b0;
            cmp_nd <= 1'b0;
            cmp_a <= '0;
            cmp_b <= '0;
            nch <= '0;
            nwin <= '0;
            ch <= '0;
            pos <= '0;
            idx <= '0;
            pending <= '0;
            for (int i = 0; i < MAX_CH; i++) max_r[i] <= '0;
        end else begin
            done <= start_empty || (state == FLUSH && out_ready && last_idx);
            cmp_nd <= issue;
            if (issue) begin
                cmp_a <= in_data;
                cmp_b <= max_r[ch];
            end
            if (start_ok) begin
                nch <= cfg_ch;
                nwin <= cfg_win;
                ch <= '0;
                pos <= '0;
            end else if (accept) begin
                ch <= last_ch ? '0 : ch + 1'b1;
                pos <= last_ch ? pos + 1'b1 : pos;
            end
            if (state == DRAIN) idx <= '0;
            else if (out_valid && out_ready) idx <= idx + 1'b1;
            if (pop_ok) begin
                pending[CH_W'(tag_out.ch)] <= 1'b0;
                if (cmp_gt) max_r[CH_W'(tag_out.ch)] <= tag_out.data;
            end
            if (accept && pos == '0) max_r[ch] <= in_data;
            if (issue) pending[ch] <= 1'b1;
        end
endmodule

// File: tb/tb_maxpool_ctrl.sv
// tb_maxpool_ctrl: randomized scenario bench with a behavioural pooling and comparator model.
module tb_maxpool_ctrl;
    localparam int CH_W = 4;
    logic clk = 0, rst = 1, cfg_start = 0;
    logic [CH_W:0] cfg_ch = 0;
    logic [7:0] cfg_win = 0;
    logic busy, done, in_valid = 0, in_ready;
    logic [15:0] in_data = 0, cmp_a, cmp_b, out_data;
    logic cmp_nd, cmp_rdy = 0, cmp_gt = 0, out_valid, out_ready = 0;
    logic [CH_W-1:0] out_ch;
    int n_vec = 0, n_err = 0, cyc = 0, lat = 1;
    int due_q[$];
    bit gt_q[$];
    logic [15:0] stim [128];
    logic [15:0] got_data[$];
    int got_ch[$];
    int n_done, stalls, hold_bad, valid_seen;
    bit busy_at_done, timed_out;

    maxpool_ctrl dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_ch(cfg_ch), .cfg_win(cfg_win),
        .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_nd(cmp_nd), .cmp_rdy(cmp_rdy), .cmp_gt(cmp_gt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit is_nan(logic [15:0] x);
        return x[14:10] == 5'h1f && x[9:0] != 0;
    endfunction
    function automatic real f2r(logic [15:0] x);
        real v = (x[14:10] == 0) ? real'(x[9:0]) : real'(1024 + int'(x[9:0]));
        int e = (x[14:10] == 0) ? 1 : int'(x[14:10]);
        for (int i = 0; i < e; i++) v = v * 2.0;
        for (int i = 0; i < 25; i++) v = v / 2.0;
        return x[15] ? -v : v;
    endfunction
    function automatic bit fp_gt(logic [15:0] a, logic [15:0] b);
        return !is_nan(a) && !is_nan(b) && f2r(a) > f2r(b);
    endfunction
    function automatic logic [15:0] ref_out(int c, int nch, int nwin);
        logic [15:0] m = stim[c];
        for (int p = 1; p < nwin; p++) if (fp_gt(stim[p*nch+c], m)) m = stim[p*nch+c];
`ifdef MAXPOOL_RELU_EN
        if (m[15]) m = 16'h0000;
`endif
        return m;
    endfunction

    // Pipelined comparator: result returns lat cycles after the strobe, in order.
    always @(negedge clk)
        if (rst) begin
            due_q.delete(); gt_q.delete(); cmp_rdy = 0; cmp_gt = 0;
        end else begin
            cmp_rdy = 0; cmp_gt = 0;
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                cmp_rdy = 1; cmp_gt = gt_q[0];
                void'(due_q.pop_front()); void'(gt_q.pop_front());
            end
            if (cmp_nd) begin due_q.push_back(cyc + lat); gt_q.push_back(fp_gt(cmp_a, cmp_b)); end
        end

    task automatic run_job(input int nch, input int nwin, input int l, input int im, input int om);
        got_data.delete(); got_ch.delete();
        n_done = 0; stalls = 0; hold_bad = 0; valid_seen = 0; busy_at_done = 1; timed_out = 0;
        lat = l;
        @(negedge clk); cfg_ch = (CH_W+1)'(nch); cfg_win = 8'(nwin); cfg_start = 1;
        @(negedge clk); cfg_start = 0;
        fork
            begin
                int i = 0, t = 0;
                while (i < nch * nwin && t < 4000) begin
                    in_valid = (im == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
                    in_data = stim[i];
                    #1;
                    if (in_valid && in_ready) i++;
                    else if (in_valid) stalls++;
                    @(negedge clk); t++;
                end
                if (i < nch * nwin) timed_out = 1;
                in_valid = 0;
            end
            begin
                int t = 0, bp = 0, after = 0;
                bit held = 0;
                logic [15:0] hd = 0;
                logic [CH_W-1:0] hc = 0;
                while (after < 3 && t < 5000) begin
                    out_ready = (om == 0) ? 1'b1 : (om == 1) ? ($urandom_range(0, 1) == 1) : (bp >= 3);
                    #2;
                    if (held && (!out_valid || out_data !== hd || out_ch !== hc)) hold_bad++;
                    held = out_valid && !out_ready; hd = out_data; hc = out_ch;
                    if (out_valid) begin valid_seen++; bp++; end
                    if (out_valid && out_ready) begin got_data.push_back(out_data); got_ch.push_back(int'(out_ch)); end
                    if (done) begin if (n_done == 0) busy_at_done = busy; n_done++; end
                    if (n_done > 0) after++;
                    @(negedge clk); t++;
                end
                if (t >= 5000) timed_out = 1;
                out_ready = 0;
            end
        join
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (3) @(negedge clk);
        n_vec++; if (busy !== 0) begin n_err++; $display("FAIL reset busy: got %b want 0", busy); end
        n_vec++; if (done !== 0) begin n_err++; $display("FAIL reset done: got %b want 0", done); end
        n_vec++; if (in_ready !== 0) begin n_err++; $display("FAIL reset in_ready: got %b want 0", in_ready); end
        n_vec++; if (cmp_nd !== 0) begin n_err++; $display("FAIL reset cmp_nd: got %b want 0", cmp_nd); end
        n_vec++; if (cmp_a !== 0 || cmp_b !== 0) begin n_err++; $display("FAIL reset cmp_ab: got %h/%h want 0/0", cmp_a, cmp_b); end
        n_vec++; if (out_valid !== 0) begin n_err++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        n_vec++; if (out_data !== 0 || out_ch !== 0) begin n_err++; $display("FAIL reset out: got %h/%0d want 0/0", out_data, out_ch); end
        rst = 0;
    endtask

    task automatic test_single;
        stim[0] = 16'h3C00; stim[1] = 16'h4000; stim[2] = 16'hBC00; stim[3] = 16'h3800;
        run_job(1, 4, 2, 0, 0);
        n_vec++; if (got_data.size() != 1 || got_data[0] !== ref_out(0, 1, 4) || got_ch[0] != 0) begin
            n_err++; $display("FAIL single result: got n=%0d data=%h want 1 x %h", got_data.size(), got_data.size() ? got_data[0] : 16'hxxxx, ref_out(0, 1, 4)); end
        n_vec++; if (stalls == 0) begin n_err++; $display("FAIL single stall: got %0d stalled cycles want >0", stalls); end
        n_vec++; if (n_done != 1 || timed_out) begin n_err++; $display("FAIL single done: got %0d pulses timeout=%b want 1", n_done, timed_out); end
        n_vec++; if (busy_at_done !== 0) begin n_err++; $display("FAIL single busy: got %b at done want 0", busy_at_done); end
    endtask

    task automatic test_interleave;
        stim[0] = 16'h3C00; stim[1] = 16'h4200; stim[2] = 16'hC000;
        stim[3] = 16'h4000; stim[4] = 16'h3800; stim[5] = 16'hBC00;
        run_job(3, 2, 1, 0, 0);
        n_vec++; if (stalls != 0) begin n_err++; $display("FAIL interleave stall: got %0d want 0", stalls); end
        n_vec++; if (got_data.size() != 3) begin n_err++; $display("FAIL interleave count: got %0d want 3", got_data.size()); end
        for (int c = 0; c < 3; c++) begin
            n_vec++; if (c >= got_data.size() || got_ch[c] != c || got_data[c] !== ref_out(c, 3, 2)) begin
                n_err++; $display("FAIL interleave ch%0d: got ch=%0d data=%h want data=%h", c,
                    c < got_ch.size() ? got_ch[c] : -1, c < got_data.size() ? got_data[c] : 16'hxxxx, ref_out(c, 3, 2)); end
        end
    endtask

    task automatic test_relu;
        stim[0] = 16'hB800; stim[1] = 16'hBC00;
        run_job(1, 2, 1, 0, 0);
        n_vec++; if (got_data.size() != 1 || got_data[0] !== ref_out(0, 1, 2)) begin
            n_err++; $display("FAIL relu: got n=%0d data=%h want %h", got_data.size(), got_data.size() ? got_data[0] : 16'hxxxx, ref_out(0, 1, 2)); end
    endtask

    task automatic test_backpressure;
        stim[0] = 16'h4400; stim[1] = 16'h3555;
        run_job(2, 1, 1, 0, 2);
        n_vec++; if (hold_bad != 0) begin n_err++; $display("FAIL bp hold: got %0d unstable cycles want 0", hold_bad); end
        n_vec++; if (valid_seen != 5) begin n_err++; $display("FAIL bp valid cycles: got %0d want 5", valid_seen); end
        for (int c = 0; c < 2; c++) begin
            n_vec++; if (c >= got_data.size() || got_ch[c] != c || got_data[c] !== ref_out(c, 2, 1)) begin
                n_err++; $display("FAIL bp ch%0d: got ch=%0d data=%h want data=%h", c,
                    c < got_ch.size() ? got_ch[c] : -1, c < got_data.size() ? got_data[c] : 16'hxxxx, ref_out(c, 2, 1)); end
        end
    endtask

    task automatic test_abort;
        lat = 1;
        @(negedge clk); cfg_ch = 2; cfg_win = 3; cfg_start = 1;
        @(negedge clk); cfg_start = 0; in_valid = 1; in_data = 16'h5000;
        repeat (3) @(negedge clk);
        #2 rst = 1;
        #1;
        n_vec++; if (busy !== 0 || in_ready !== 0 || done !== 0) begin n_err++; $display("FAIL abort ctl: got busy=%b in_ready=%b done=%b want 0", busy, in_ready, done); end
        n_vec++; if (cmp_nd !== 0 || cmp_a !== 0 || cmp_b !== 0) begin n_err++; $display("FAIL abort cmp: got nd=%b a=%h b=%h want 0", cmp_nd, cmp_a, cmp_b); end
        n_vec++; if (out_valid !== 0 || out_data !== 0) begin n_err++; $display("FAIL abort out: got %b/%h want 0/0", out_valid, out_data); end
        in_valid = 0;
        @(negedge clk); rst = 0;
        stim[0] = 16'hBC00; stim[1] = 16'hC000;
        run_job(1, 2, 1, 0, 0);
        n_vec++; if (got_data.size() != 1 || got_data[0] !== ref_out(0, 1, 2) || n_done != 1) begin
            n_err++; $display("FAIL abort fresh: got n=%0d data=%h done=%0d want 1 x %h", got_data.size(), got_data.size() ? got_data[0] : 16'hxxxx, n_done, ref_out(0, 1, 2)); end
    endtask

    task automatic test_empty;
        run_job(2, 0, 1, 0, 0);
        n_vec++; if (n_done != 1 || valid_seen != 0) begin n_err++; $display("FAIL empty win: got done=%0d valid=%0d want 1/0", n_done, valid_seen); end
        run_job(0, 3, 1, 0, 0);
        n_vec++; if (n_done != 1 || valid_seen != 0) begin n_err++; $display("FAIL empty ch: got done=%0d valid=%0d want 1/0", n_done, valid_seen); end
    endtask

    task automatic test_nan;
        stim[0] = 16'h3C00; stim[1] = 16'h7E00;
        run_job(1, 2, 2, 0, 0);
        n_vec++; if (got_data.size() != 1 || got_data[0] !== 16'h3C00) begin
            n_err++; $display("FAIL nan: got n=%0d data=%h want 3c00", got_data.size(), got_data.size() ? got_data[0] : 16'hxxxx); end
    endtask

    task automatic test_random;
        for (int j = 0; j < 8; j++) begin
            int nch = $urandom_range(1, 16), nwin = $urandom_range(1, 6);
            for (int i = 0; i < nch * nwin; i++)
                stim[i] = ($urandom_range(0, 7) == 0) ? 16'h7E00 : 16'($urandom);
            run_job(nch, nwin, $urandom_range(1, 3), 1, 1);
            n_vec++; if (n_done != 1 || timed_out || hold_bad != 0 || got_data.size() != nch) begin
                n_err++; $display("FAIL random job%0d: got done=%0d timeout=%b hold=%0d n=%0d want 1/0/0/%0d", j, n_done, timed_out, hold_bad, got_data.size(), nch); end
            for (int c = 0; c < nch; c++) begin
                n_vec++; if (c >= got_data.size() || got_ch[c] != c || got_data[c] !== ref_out(c, nch, nwin)) begin
                    n_err++; $display("FAIL random job%0d ch%0d: got ch=%0d data=%h want data=%h", j, c,
                        c < got_ch.size() ? got_ch[c] : -1, c < got_data.size() ? got_data[c] : 16'hxxxx, ref_out(c, nch, nwin)); end
            end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_interleave;
        test_relu;
        test_backpressure;
        test_abort;
        test_empty;
        test_nan;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
